// File: rtl/cw_executor_if.sv
`default_nettype none
// ============================================================================
//  Module      : cw_executor_if
//  Description : Bundle between the control-word executor, the microprogram
//                sequencer (cw_in/cw_valid/stall), the datapath strobes
//                (reg_we/alu_op/alu_go/pc_inc/bus_oh) and the instruction /
//                data RAM handshake (mem_req/mem_we/mem_sel/mem_ack), plus
//                status (err/exec_count).
//                master : the executor side (drives strobes, stall, mem_*)
//                slave  : the environment side (drives cw_in, cw_valid,
//                         mem_ack)
//  Revision    : 1.0 - initial release
// ============================================================================
interface cw_executor_if #(
    parameter int CW_W    = 38,
    parameter int WE_W    = 19,
    parameter int NUM_SRC = 17,
    parameter int CNT_W   = 16
);
    logic [CW_W-1:0]    cw_in;
    logic               cw_valid;
    logic               stall;
    logic [WE_W-1:0]    reg_we;
    logic [3:0]         alu_op;
    logic               alu_go;
    logic               pc_inc;
    logic [NUM_SRC-1:0] bus_oh;
    logic               mem_req;
    logic               mem_we;
    logic               mem_sel;
    logic               mem_ack;
    logic [2:0]         err;
    logic [CNT_W-1:0]   exec_count;

    modport master (
        input  cw_in, cw_valid, mem_ack,
        output stall, reg_we, alu_op, alu_go, pc_inc, bus_oh,
               mem_req, mem_we, mem_sel, err, exec_count
    );

    modport slave (
        output cw_in, cw_valid, mem_ack,
        input  stall, reg_we, alu_op, alu_go, pc_inc, bus_oh,
               mem_req, mem_we, mem_sel, err, exec_count
    );
endinterface
`default_nettype wire

// File: rtl/cw_executor.sv
`default_nettype none
// ============================================================================
//  Module      : cw_executor
//  Description : Turns each microinstruction word from the sequencer into
//                one-cycle datapath strobes, and runs a memory handshake
//                (with timeout) for words carrying a memory field, stalling
//                the sequencer meanwhile.
//  Ports       : clk   - system clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - cw_executor_if.master (control word in, stall,
//                        strobes, memory handshake, err, exec_count)
//  Revision    : 1.0 - initial release
// ============================================================================
module cw_executor #(
    parameter int CW_W    = 38,
    parameter int WE_W    = 19,
    parameter int NUM_SRC = 17,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    cw_executor_if.master  bus
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_STROBE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         alu_op_q, alu_op_d;
    logic [WE_W-1:0]    we_q, we_d;
    logic               pc_inc_q, pc_inc_d;
    logic [4:0]         bus_code_q, bus_code_d;
    logic               mem_we_q, mem_we_d;
    logic               mem_sel_q, mem_sel_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [2:0]         err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               w_capture;
    logic               w_mem_op;
    logic               w_mem_we;
    logic               w_mem_sel;
    logic               w_mem_bad;
    logic               w_strobe;
    logic [NUM_SRC-1:0] w_bus_oh;
    logic               w_unused_next;

    // Next-address field belongs to the sequencer only.
    assign w_unused_next = ^bus.cw_in[CW_W-1:32];

    // Sequencer is only held while a memory request is outstanding.
    assign w_capture = bus.cw_valid && (state_q != ST_REQ);

    always_comb begin
        w_mem_op  = 1'b0;
        w_mem_we  = 1'b0;
        w_mem_sel = 1'b0;
        w_mem_bad = 1'b0;
        case (bus.cw_in[8:6])
            3'b000: ;
            3'b100: w_mem_op = 1'b1;
            3'b010: begin w_mem_op = 1'b1; w_mem_sel = 1'b1; end
            3'b001: begin w_mem_op = 1'b1; w_mem_sel = 1'b1; w_mem_we = 1'b1; end
            default: w_mem_bad = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        alu_op_d   = alu_op_q;
        we_d       = we_q;
        pc_inc_d   = pc_inc_q;
        bus_code_d = bus_code_q;
        mem_we_d   = mem_we_q;
        mem_sel_d  = mem_sel_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_REQ: begin
                // Ack is checked before the timeout so a coincident ack wins.
                if (bus.mem_ack) begin
                    state_d = ST_STROBE;
                    tmo_d   = '0;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d  = ST_IDLE;
                    tmo_d    = '0;
                    err_d[1] = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                if (w_capture) begin
                    alu_op_d   = bus.cw_in[31:28];
                    we_d       = bus.cw_in[9 +: WE_W];
                    pc_inc_d   = bus.cw_in[5];
                    bus_code_d = bus.cw_in[4:0];
                    mem_we_d   = w_mem_we;
                    mem_sel_d  = w_mem_sel;
                    tmo_d      = '0;
                    state_d    = w_mem_op ? ST_REQ : ST_STROBE;
                    if (w_mem_bad) begin
                        err_d[0] = 1'b1;
                    end
                    if (bus.cw_in[4:0] > 5'(NUM_SRC)) begin
                        err_d[2] = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        // Counted on entry so the count already includes the word being strobed.
        if ((state_d == ST_STROBE) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            alu_op_q   <= '0;
            we_q       <= '0;
            pc_inc_q   <= 1'b0;
            bus_code_q <= '0;
            mem_we_q   <= 1'b0;
            mem_sel_q  <= 1'b0;
            tmo_q      <= '0;
            err_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            alu_op_q   <= alu_op_d;
            we_q       <= we_d;
            pc_inc_q   <= pc_inc_d;
            bus_code_q <= bus_code_d;
            mem_we_q   <= mem_we_d;
            mem_sel_q  <= mem_sel_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign w_strobe = (state_q == ST_STROBE);

    // Codes 0 and above NUM_SRC match no bit and leave the bus undriven.
    always_comb begin
        w_bus_oh = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_bus_oh[k] = w_strobe && (bus_code_q == 5'(k + 1));
        end
    end

    // Outputs decode straight from registered state, so reset clears them at once.
    assign bus.stall      = (state_q == ST_REQ);
    assign bus.mem_req    = (state_q == ST_REQ);
    assign bus.mem_we     = (state_q == ST_REQ) && mem_we_q;
    assign bus.mem_sel    = (state_q == ST_REQ) && mem_sel_q;
    assign bus.reg_we     = w_strobe ? we_q : '0;
    assign bus.alu_op     = w_strobe ? alu_op_q : 4'd0;
    assign bus.alu_go     = w_strobe && (alu_op_q != 4'd0);
    assign bus.pc_inc     = w_strobe && pc_inc_q;
    assign bus.bus_oh     = w_bus_oh;
    assign bus.err        = err_q;
    assign bus.exec_count = cnt_q;
endmodule
`default_nettype wire
